// File: rtl/vol_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vol_pkg
//  Description : Shared definitions for the volatility window controller:
//                default sizing, FSM state encoding and the window-depth
//                clamp helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package vol_pkg;

    localparam int VW_NUM_STOCKS = 4;
    localparam int VW_MAX_DEPTH  = 32;

    typedef enum logic [0:0] {
        VW_RUN   = 1'b0,
        VW_FLUSH = 1'b1
    } vw_state_t;

    // A window shorter than 2 would make every sample evict itself.
    function automatic int clamp_depth(input int req, input int max_depth);
        if (req < 2)
            return 2;
        else if (req > max_depth)
            return max_depth;
        else
            return req;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vol_window_ptr.sv
`default_nettype none
// ============================================================================
//  Module      : vol_window_ptr
//  Description : Write pointer and fill count of one stock's circular window.
//                The pointer wraps at the active depth and fill saturates
//                there. A clear takes effect ahead of a same-cycle advance.
//  Ports       : i_clk, i_reset_n (sync, active-low)
//                i_clear   - zero pointer and fill
//                i_advance - a sample is written to this window
//                i_depth   - active window depth
//                o_wptr    - pointer as seen by this cycle's sample
//                o_fill    - fill as seen by this cycle's sample
//  Revision    : 1.0 - initial release
// ============================================================================
module vol_window_ptr #(
    parameter int DEPTH_W = 6
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_clear,
    input  logic               i_advance,
    input  logic [DEPTH_W-1:0] i_depth,
    output logic [DEPTH_W-1:0] o_wptr,
    output logic [DEPTH_W-1:0] o_fill
);

    logic [DEPTH_W-1:0] r_wptr;
    logic [DEPTH_W-1:0] r_fill;
    logic [DEPTH_W-1:0] w_wptr_inc;

    // Expose the post-clear view so a same-cycle sample lands on slot 0.
    assign o_wptr     = i_clear ? '0 : r_wptr;
    assign o_fill     = i_clear ? '0 : r_fill;
    assign w_wptr_inc = o_wptr + 1'b1;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_wptr <= '0;
            r_fill <= '0;
        end else if (i_advance) begin
            r_wptr <= (w_wptr_inc == i_depth) ? '0 : w_wptr_inc;
            r_fill <= (o_fill == i_depth) ? o_fill : o_fill + 1'b1;
        end else if (i_clear) begin
            r_wptr <= '0;
            r_fill <= '0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/volatility_window_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : volatility_window_ctrl
//  Description : Per-stock circular-window address controller for the
//                volatility sample buffer. Produces RAM write addresses,
//                eviction flags and fill levels one cycle after each sample.
//                A depth change is followed by a one-cycle FLUSH that empties
//                every window.
//  Options     : VOL_CTRL_EVICT_CNT_EN adds per-stock 16-bit saturating
//                eviction counters (ports i_cnt_id / o_evict_cnt).
//  Ports       : i_clk, i_reset_n (sync, active-low)
//                i_data_valid/i_stock_id -> o_valid/o_stock_id/o_wr_addr/
//                o_evict_valid/o_fill/o_full, o_drop for bad stock ids
//                i_flush/i_flush_id  - clear one stock's window
//                i_cfg_valid/i_cfg_depth - new depth, o_depth active depth
//                o_ready/o_cfg_ready - low only in the FLUSH cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module volatility_window_ctrl
    import vol_pkg::*;
#(
    parameter  int NUM_STOCKS = VW_NUM_STOCKS,
    parameter  int MAX_DEPTH  = VW_MAX_DEPTH,
    localparam int DEPTH_W    = $clog2(MAX_DEPTH + 1),
    localparam int ADDR_W     = $clog2(NUM_STOCKS * MAX_DEPTH),
    localparam int SID_W      = (NUM_STOCKS > 1) ? $clog2(NUM_STOCKS) : 1
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_data_valid,
    input  logic [SID_W-1:0]   i_stock_id,
    output logic               o_ready,
    input  logic               i_flush,
    input  logic [SID_W-1:0]   i_flush_id,
    input  logic               i_cfg_valid,
    input  logic [DEPTH_W-1:0] i_cfg_depth,
    output logic               o_cfg_ready,
    output logic               o_valid,
    output logic [SID_W-1:0]   o_stock_id,
    output logic [ADDR_W-1:0]  o_wr_addr,
    output logic               o_evict_valid,
    output logic [DEPTH_W-1:0] o_fill,
    output logic               o_full,
    output logic               o_drop,
`ifdef VOL_CTRL_EVICT_CNT_EN
    input  logic [SID_W-1:0]   i_cnt_id,
    output logic [15:0]        o_evict_cnt,
`endif
    output logic [DEPTH_W-1:0] o_depth
);

    localparam logic [SID_W:0] c_SID_LIMIT = (SID_W + 1)'(NUM_STOCKS);

    vw_state_t          r_state;
    logic [DEPTH_W-1:0] r_depth;

    logic               w_run;
    logic               w_sid_ok;
    logic               w_accept;
    logic [DEPTH_W-1:0] w_wptr [NUM_STOCKS];
    logic [DEPTH_W-1:0] w_fill [NUM_STOCKS];
    logic               w_clear[NUM_STOCKS];
    logic               w_adv  [NUM_STOCKS];
    logic [DEPTH_W-1:0] w_sel_wptr;
    logic [DEPTH_W-1:0] w_sel_fill;
    logic [ADDR_W-1:0]  w_sel_base;
    logic [DEPTH_W-1:0] w_fill_next;
    logic               w_evict;
    logic [DEPTH_W-1:0] w_cfg_depth;

    assign w_run       = (r_state == VW_RUN);
    assign w_sid_ok    = ({1'b0, i_stock_id} < c_SID_LIMIT);
    assign w_accept    = w_run && i_data_valid && w_sid_ok;
    assign o_ready     = w_run;
    assign o_cfg_ready = w_run;
    assign o_depth     = r_depth;
    assign w_cfg_depth = DEPTH_W'(clamp_depth(int'(i_cfg_depth), MAX_DEPTH));

    generate
        for (genvar g = 0; g < NUM_STOCKS; g++) begin : g_win
            // FLUSH empties all windows; no sample is accepted in that cycle.
            assign w_clear[g] = (r_state == VW_FLUSH) ||
                                (w_run && i_flush && (i_flush_id == SID_W'(g)));
            assign w_adv[g]   = w_accept && (i_stock_id == SID_W'(g));

            vol_window_ptr #(
                .DEPTH_W (DEPTH_W)
            ) u_ptr (
                .i_clk     (i_clk),
                .i_reset_n (i_reset_n),
                .i_clear   (w_clear[g]),
                .i_advance (w_adv[g]),
                .i_depth   (r_depth),
                .o_wptr    (w_wptr[g]),
                .o_fill    (w_fill[g])
            );
        end
    endgenerate

    // Select the addressed stock; base is a constant stride, no multiplier.
    always_comb begin
        w_sel_wptr = '0;
        w_sel_fill = '0;
        w_sel_base = '0;
        for (int s = 0; s < NUM_STOCKS; s++) begin
            if (i_stock_id == SID_W'(s)) begin
                w_sel_wptr = w_wptr[s];
                w_sel_fill = w_fill[s];
                w_sel_base = ADDR_W'(s * MAX_DEPTH);
            end
        end
    end

    assign w_evict     = (w_sel_fill == r_depth);
    assign w_fill_next = w_evict ? r_depth : w_sel_fill + 1'b1;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state       <= VW_RUN;
            r_depth       <= DEPTH_W'(MAX_DEPTH);
            o_valid       <= 1'b0;
            o_evict_valid <= 1'b0;
            o_drop        <= 1'b0;
            o_full        <= 1'b0;
            o_wr_addr     <= '0;
            o_fill        <= '0;
            o_stock_id    <= '0;
        end else begin
            o_valid       <= w_accept;
            o_evict_valid <= w_accept && w_evict;
            o_drop        <= w_run && i_data_valid && !w_sid_ok;
            if (w_accept) begin
                o_stock_id <= i_stock_id;
                o_wr_addr  <= w_sel_base + ADDR_W'(w_sel_wptr);
                o_fill     <= w_fill_next;
                o_full     <= (w_fill_next == r_depth);
            end
            case (r_state)
                VW_RUN: begin
                    if (i_cfg_valid) begin
                        r_depth <= w_cfg_depth;
                        r_state <= VW_FLUSH;
                    end
                end
                default: r_state <= VW_RUN;
            endcase
        end
    end

`ifdef VOL_CTRL_EVICT_CNT_EN
    logic [15:0] r_evict_cnt [NUM_STOCKS];

    generate
        for (genvar g = 0; g < NUM_STOCKS; g++) begin : g_cnt
            always_ff @(posedge i_clk) begin
                if (!i_reset_n || w_clear[g])
                    r_evict_cnt[g] <= '0;
                else if (w_adv[g] && w_evict && (r_evict_cnt[g] != 16'hFFFF))
                    r_evict_cnt[g] <= r_evict_cnt[g] + 16'd1;
            end
        end
    endgenerate

    always_comb begin
        o_evict_cnt = '0;
        for (int s = 0; s < NUM_STOCKS; s++) begin
            if (i_cnt_id == SID_W'(s))
                o_evict_cnt = r_evict_cnt[s];
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_volatility_window_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_volatility_window_ctrl
//  Description : Directed, table-driven self-checking bench for
//                volatility_window_ctrl (3 stocks, max depth 32).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_volatility_window_ctrl;

    localparam int NS = 3;
    localparam int MD = 32;
    localparam int DW = 6;
    localparam int AW = 7;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          data_valid;
    logic [SW-1:0] stock_id;
    logic          ready;
    logic          flush;
    logic [SW-1:0] flush_id;
    logic          cfg_valid;
    logic [DW-1:0] cfg_depth;
    logic          cfg_ready;
    logic          valid;
    logic [SW-1:0] o_sid;
    logic [AW-1:0] wr_addr;
    logic          evict;
    logic [DW-1:0] fill;
    logic          full;
    logic          drop;
    logic [DW-1:0] depth;
`ifdef VOL_CTRL_EVICT_CNT_EN
    logic [SW-1:0] cnt_id;
    logic [15:0]   evict_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    volatility_window_ctrl #(
        .NUM_STOCKS (NS),
        .MAX_DEPTH  (MD)
    ) dut (
        .i_clk         (clk),
        .i_reset_n     (reset_n),
        .i_data_valid  (data_valid),
        .i_stock_id    (stock_id),
        .o_ready       (ready),
        .i_flush       (flush),
        .i_flush_id    (flush_id),
        .i_cfg_valid   (cfg_valid),
        .i_cfg_depth   (cfg_depth),
        .o_cfg_ready   (cfg_ready),
        .o_valid       (valid),
        .o_stock_id    (o_sid),
        .o_wr_addr     (wr_addr),
        .o_evict_valid (evict),
        .o_fill        (fill),
        .o_full        (full),
        .o_drop        (drop),
`ifdef VOL_CTRL_EVICT_CNT_EN
        .i_cnt_id      (cnt_id),
        .o_evict_cnt   (evict_cnt),
`endif
        .o_depth       (depth)
    );

    typedef struct {
        bit v;   int sid; bit fl; int fid; bit cf; int cd;
        bit ev;  int ea;  bit eev; int efill; bit efull;
        bit edrop; bit erdy; int edep;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(bit v, int sid, bit fl, int fid, bit cf, int cd,
                                bit ev, int ea, bit eev, int efill, bit efull,
                                bit edrop, bit erdy, int edep);
        vec_t r;
        r.v = v; r.sid = sid; r.fl = fl; r.fid = fid; r.cf = cf; r.cd = cd;
        r.ev = ev; r.ea = ea; r.eev = eev; r.efill = efill; r.efull = efull;
        r.edrop = edrop; r.erdy = erdy; r.edep = edep;
        return r;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input bit v, input int sid, input bit fl, input int fid,
                         input bit cf, input int cd);
        int t_sid;
        int t_fid;
        int t_cd;
        t_sid = sid; t_fid = fid; t_cd = cd;
        data_valid = v;
        stock_id   = t_sid[SW-1:0];
        flush      = fl;
        flush_id   = t_fid[SW-1:0];
        cfg_valid  = cf;
        cfg_depth  = t_cd[DW-1:0];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_sample(input string nm, input int ea, input bit eev,
                                input int efill, input bit efull);
        chk({nm, " valid"}, int'(valid), 1);
        chk({nm, " addr"},  int'(wr_addr), ea);
        chk({nm, " evict"}, int'(evict), int'(eev));
        chk({nm, " fill"},  int'(fill), efill);
        chk({nm, " full"},  int'(full), int'(efull));
    endtask

    initial begin
        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
`ifdef VOL_CTRL_EVICT_CNT_EN
        cnt_id = '0;
`endif
        step();
        step();
        chk("rst valid", int'(valid), 0);
        chk("rst evict", int'(evict), 0);
        chk("rst drop",  int'(drop), 0);
        chk("rst full",  int'(full), 0);
        chk("rst addr",  int'(wr_addr), 0);
        chk("rst fill",  int'(fill), 0);
        chk("rst sid",   int'(o_sid), 0);
        chk("rst depth", int'(depth), 32);
        chk("rst ready", int'(ready), 1);
        reset_n = 1'b1;

        // Stock 2 at depth 32: 33 samples wrap back to its base.
        for (int k = 1; k <= 33; k++) begin
            drive(1, 2, 0, 0, 0, 0);
            step();
            check_sample($sformatf("wrap%0d", k), 64 + ((k - 1) % 32),
                         k == 33, (k < 32) ? k : 32, k >= 32);
            chk($sformatf("wrap%0d sid", k), int'(o_sid), 2);
        end

        //           v sid fl fid cf cd   ev  ea eev fill full drop rdy dep
        vq.push_back(mk(0,0, 0,0, 1,4,    0,  0, 0, 0, 0,   0, 0, 4));
        vq.push_back(mk(1,1, 0,0, 0,0,    0,  0, 0, 0, 0,   0, 1, 4));
        vq.push_back(mk(1,1, 0,0, 0,0,    1, 32, 0, 1, 0,   0, 1, 4));
        vq.push_back(mk(1,1, 0,0, 0,0,    1, 33, 0, 2, 0,   0, 1, 4));
        vq.push_back(mk(1,1, 0,0, 0,0,    1, 34, 0, 3, 0,   0, 1, 4));
        vq.push_back(mk(1,1, 0,0, 0,0,    1, 35, 0, 4, 1,   0, 1, 4));
        vq.push_back(mk(1,1, 0,0, 0,0,    1, 32, 1, 4, 1,   0, 1, 4));
        vq.push_back(mk(1,1, 0,0, 0,0,    1, 33, 1, 4, 1,   0, 1, 4));
        vq.push_back(mk(1,2, 0,0, 0,0,    1, 64, 0, 1, 0,   0, 1, 4));
        vq.push_back(mk(0,0, 0,0, 1,1,    0,  0, 0, 0, 0,   0, 0, 2));
        vq.push_back(mk(0,0, 0,0, 0,0,    0,  0, 0, 0, 0,   0, 1, 2));
        vq.push_back(mk(0,0, 0,0, 1,40,   0,  0, 0, 0, 0,   0, 0, 32));
        vq.push_back(mk(0,0, 0,0, 0,0,    0,  0, 0, 0, 0,   0, 1, 32));
        vq.push_back(mk(1,2, 0,0, 0,0,    1, 64, 0, 1, 0,   0, 1, 32));
        vq.push_back(mk(1,0, 0,0, 0,0,    1,  0, 0, 1, 0,   0, 1, 32));
        vq.push_back(mk(1,0, 0,0, 0,0,    1,  1, 0, 2, 0,   0, 1, 32));
        vq.push_back(mk(1,0, 0,0, 0,0,    1,  2, 0, 3, 0,   0, 1, 32));
        vq.push_back(mk(1,0, 1,0, 0,0,    1,  0, 0, 1, 0,   0, 1, 32));
        vq.push_back(mk(1,0, 0,0, 0,0,    1,  1, 0, 2, 0,   0, 1, 32));
        vq.push_back(mk(1,0, 1,2, 0,0,    1,  2, 0, 3, 0,   0, 1, 32));
        vq.push_back(mk(1,2, 0,0, 0,0,    1, 64, 0, 1, 0,   0, 1, 32));
        vq.push_back(mk(1,3, 0,0, 0,0,    0,  0, 0, 0, 0,   1, 1, 32));
        vq.push_back(mk(0,0, 0,0, 0,0,    0,  0, 0, 0, 0,   0, 1, 32));
        vq.push_back(mk(1,0, 0,0, 0,0,    1,  3, 0, 4, 0,   0, 1, 32));
        vq.push_back(mk(1,0, 0,0, 1,8,    1,  4, 0, 5, 0,   0, 0, 8));
        vq.push_back(mk(1,0, 1,0, 1,3,    0,  0, 0, 0, 0,   0, 1, 8));
        vq.push_back(mk(1,0, 0,0, 0,0,    1,  0, 0, 1, 0,   0, 1, 8));
        vq.push_back(mk(0,0, 0,0, 1,2,    0,  0, 0, 0, 0,   0, 0, 2));
        vq.push_back(mk(0,0, 0,0, 0,0,    0,  0, 0, 0, 0,   0, 1, 2));
        vq.push_back(mk(1,1, 0,0, 0,0,    1, 32, 0, 1, 0,   0, 1, 2));
        vq.push_back(mk(1,1, 0,0, 0,0,    1, 33, 0, 2, 1,   0, 1, 2));
        vq.push_back(mk(1,1, 0,0, 0,0,    1, 32, 1, 2, 1,   0, 1, 2));
        vq.push_back(mk(1,1, 0,0, 0,0,    1, 33, 1, 2, 1,   0, 1, 2));
        vq.push_back(mk(1,1, 0,0, 0,0,    1, 32, 1, 2, 1,   0, 1, 2));

        foreach (vq[i]) begin
            drive(vq[i].v, vq[i].sid, vq[i].fl, vq[i].fid, vq[i].cf, vq[i].cd);
            step();
            chk($sformatf("vec%0d valid", i), int'(valid), int'(vq[i].ev));
            chk($sformatf("vec%0d evict", i), int'(evict), int'(vq[i].eev));
            chk($sformatf("vec%0d drop", i),  int'(drop),  int'(vq[i].edrop));
            chk($sformatf("vec%0d ready", i), int'(ready), int'(vq[i].erdy));
            chk($sformatf("vec%0d cfgrdy", i), int'(cfg_ready), int'(vq[i].erdy));
            chk($sformatf("vec%0d depth", i), int'(depth), vq[i].edep);
            if (vq[i].ev) begin
                chk($sformatf("vec%0d addr", i), int'(wr_addr), vq[i].ea);
                chk($sformatf("vec%0d fill", i), int'(fill), vq[i].efill);
                chk($sformatf("vec%0d full", i), int'(full), int'(vq[i].efull));
                chk($sformatf("vec%0d sid", i),  int'(o_sid), vq[i].sid);
            end
        end

`ifdef VOL_CTRL_EVICT_CNT_EN
        drive(0, 0, 0, 0, 0, 0);
        cnt_id = 2'd1;
        #1;
        chk("cnt stock1", int'(evict_cnt), 3);
        cnt_id = 2'd0;
        #1;
        chk("cnt stock0", int'(evict_cnt), 0);
        drive(0, 0, 1, 1, 0, 0);
        cnt_id = 2'd1;
        step();
        chk("cnt after flush", int'(evict_cnt), 0);
`endif

        // Reset in the middle of traffic.
        reset_n = 1'b0;
        drive(1, 0, 0, 0, 1, 4);
        step();
        chk("midrst valid", int'(valid), 0);
        chk("midrst addr",  int'(wr_addr), 0);
        chk("midrst fill",  int'(fill), 0);
        chk("midrst depth", int'(depth), 32);
        chk("midrst ready", int'(ready), 1);
        reset_n = 1'b1;
        drive(1, 1, 0, 0, 0, 0);
        step();
        check_sample("postrst", 32, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
